// File: rtl/midori_share_codec.sv
// ---------------------------------------------------------------------------
// midori_share_codec
//
// Front/back end for the 3-share masked Midori S-box pipeline. Each accepted
// plaintext nibble is split into three Boolean shares using fresh randomness
// and registered onto sh_in1..3. A tag bit travels alongside it down a shift
// line that matches the external S-box depth. When the tag reaches the last
// stage, the returning shares are XOR-recombined straight into a small result
// FIFO. The S-box pipeline cannot stall, so input acceptance is gated by a
// credit rule: outstanding nibbles plus buffered results must stay below
// FIFO_DEPTH. That guarantees every returning result has a FIFO slot.
//
// Parameters
//   SBOX_LAT    cycles from sh_in* registered to matching sh_out* valid
//   FIFO_DEPTH  result FIFO entries == maximum outstanding nibbles (>=1)
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   in_valid/in_ready   plaintext handshake, in_data is the nibble
//   rnd                 fresh mask bits every cycle, m1=rnd[3:0], m2=rnd[7:4]
//   sh_in1..3           registered shares to the masked S-box
//   sh_out1..3          shares returning from the masked S-box
//   out_valid/out_ready result handshake, out_data is the FIFO head
//   err_ovf             sticky flag: a result arrived with the FIFO full
// ---------------------------------------------------------------------------
module midori_share_codec #(
    parameter int SBOX_LAT   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic [7:0] rnd,
    output logic [3:0] sh_in1,
    output logic [3:0] sh_in2,
    output logic [3:0] sh_in3,
    input  logic [3:0] sh_out1,
    input  logic [3:0] sh_out2,
    input  logic [3:0] sh_out3,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic       err_ovf
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [3:0]          sh1_q, sh1_d;
    logic [3:0]          sh2_q, sh2_d;
    logic [3:0]          sh3_q, sh3_d;
    logic                tag_q, tag_d;
    logic [SBOX_LAT-1:0] line_q, line_d;
    logic [CW-1:0]       inflight_q, inflight_d;
    logic [CW-1:0]       count_q, count_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [3:0]          mem_q [FIFO_DEPTH];
    logic [3:0]          mem_d [FIFO_DEPTH];
    logic                err_q, err_d;

    logic [CW:0]         credit_used;
    logic                accept;
    logic                pop;
    logic                full;
    logic                push_req;
    logic                push;
    logic [3:0]          m1;
    logic [3:0]          m2;
    logic [3:0]          recombined;

    // Handshake and credit decode. in_ready looks only at registered
    // occupancy (before this cycle's pop), so there is no combinational path
    // from out_ready to in_ready. A push into a full FIFO is still honoured
    // when the head leaves in the same cycle.
    always_comb begin
        m1          = rnd[3:0];
        m2          = rnd[7:4];
        credit_used = {1'b0, inflight_q} + {1'b0, count_q};
        in_ready    = !rst && (credit_used < (CW + 1)'(FIFO_DEPTH));
        accept      = in_valid && in_ready;
        pop         = (count_q != '0) && out_ready;
        full        = (count_q == CW'(FIFO_DEPTH));
        push_req    = line_q[SBOX_LAT-1];
        push        = push_req && (!full || pop);
        recombined  = sh_out1 ^ sh_out2 ^ sh_out3;
    end

    // Next-state logic. The shares are reloaded with fresh masks every cycle;
    // an idle cycle sends a masked zero, so the S-box never sees stale data
    // and the plaintext only ever appears XORed with both masks.
    always_comb begin
        sh1_d = m1;
        sh2_d = m2;
        sh3_d = m1 ^ m2 ^ (accept ? in_data : 4'h0);
        tag_d = accept;

        line_d[0] = tag_q;
        for (int i = 1; i < SBOX_LAT; i++) begin
            line_d[i] = line_q[i-1];
        end

        inflight_d = inflight_q;
        case ({accept, push_req})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = recombined;
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end

        // A result with nowhere to go is lost; remember that it happened.
        err_d = err_q | (push_req && !push);
    end

    // Control and share registers. Reset drops every in-flight tag and every
    // buffered result, so nothing from before the reset can surface later.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh1_q      <= '0;
            sh2_q      <= '0;
            sh3_q      <= '0;
            tag_q      <= 1'b0;
            line_q     <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            sh1_q      <= sh1_d;
            sh2_q      <= sh2_d;
            sh3_q      <= sh3_d;
            tag_q      <= tag_d;
            line_q     <= line_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
        end
    end

    // FIFO storage needs no reset: out_data is forced to zero while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign sh_in1    = sh1_q;
    assign sh_in2    = sh2_q;
    assign sh_in3    = sh3_q;
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : 4'h0;
    assign err_ovf   = err_q;

endmodule

// File: tb/tb_midori_share_codec.sv
// ---------------------------------------------------------------------------
// tb_midori_share_codec
//
// Self-checking bench for midori_share_codec. A behavioural 3-share S-box
// (depth SBOX_LAT, Midori Sb0, re-masked) sits on the share ports. A
// queue-based reference model tracks which nibbles are outstanding, when
// each result is due, and what the result FIFO holds. Every cycle the DUT
// outputs are compared with that model. Directed sequences add literal
// expectations for latency, backpressure, streaming and reset.
// ---------------------------------------------------------------------------
module tb_midori_share_codec;

    localparam int SBOX_LAT   = 4;
    localparam int FIFO_DEPTH = 6;

    localparam logic [3:0] SB0 [16] = '{4'hC, 4'hA, 4'hD, 4'h3, 4'hE, 4'hB, 4'hF, 4'h7,
                                        4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6};

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [7:0] rnd;
    logic [3:0] sh_in1, sh_in2, sh_in3;
    logic [3:0] sh_out1, sh_out2, sh_out3;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       err_ovf;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [3:0] val;
        int         due;
    } pend_t;

    pend_t      pend_q[$];
    logic [3:0] fifo_m[$];
    logic [3:0] got_q[$];
    logic       mdl_err  = 1'b0;
    logic       mdl_live = 1'b0;
    logic [3:0] exp_m1   = 4'h0;
    logic [3:0] exp_m2   = 4'h0;
    logic [3:0] exp_xor  = 4'h0;
    int         edge_n   = 0;

    logic [3:0] sb_s1 [SBOX_LAT];
    logic [3:0] sb_s2 [SBOX_LAT];
    logic [3:0] sb_s3 [SBOX_LAT];

    midori_share_codec #(
        .SBOX_LAT  (SBOX_LAT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .rnd      (rnd),
        .sh_in1   (sh_in1),
        .sh_in2   (sh_in2),
        .sh_in3   (sh_in3),
        .sh_out1  (sh_out1),
        .sh_out2  (sh_out2),
        .sh_out3  (sh_out3),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .err_ovf  (err_ovf)
    );

    always #5 clk = ~clk;

    // Behavioural masked S-box: unmask, look up Sb0, re-share with a fresh
    // random mask, then delay SBOX_LAT cycles.
    always @(posedge clk) begin
        logic [3:0] r;
        logic [3:0] x;
        r = 4'($urandom);
        x = sh_in1 ^ sh_in2 ^ sh_in3;
        sb_s1[0] <= sh_in1 ^ r;
        sb_s2[0] <= sh_in2;
        sb_s3[0] <= SB0[x] ^ sh_in1 ^ r ^ sh_in2;
        for (int k = 1; k < SBOX_LAT; k++) begin
            sb_s1[k] <= sb_s1[k-1];
            sb_s2[k] <= sb_s2[k-1];
            sb_s3[k] <= sb_s3[k-1];
        end
    end

    assign sh_out1 = sb_s1[SBOX_LAT-1];
    assign sh_out2 = sb_s2[SBOX_LAT-1];
    assign sh_out3 = sb_s3[SBOX_LAT-1];

    function automatic bit mdl_ready();
        return !rst && ((pend_q.size() + fifo_m.size()) < FIFO_DEPTH);
    endfunction

    // Reference model: outstanding nibbles are kept with the edge number at
    // which their result lands in the FIFO (SBOX_LAT+1 edges after accept).
    always @(posedge clk) begin
        bit    rdy;
        bit    acc;
        pend_t e;
        if (rst) begin
            pend_q.delete();
            fifo_m.delete();
            mdl_err  = 1'b0;
            exp_m1   = 4'h0;
            exp_m2   = 4'h0;
            exp_xor  = 4'h0;
            mdl_live = 1'b1;
        end else begin
            rdy = (pend_q.size() + fifo_m.size()) < FIFO_DEPTH;
            acc = in_valid && rdy;
            if (fifo_m.size() > 0 && out_ready) void'(fifo_m.pop_front());
            while (pend_q.size() > 0 && pend_q[0].due == edge_n) begin
                if (fifo_m.size() < FIFO_DEPTH) fifo_m.push_back(SB0[pend_q[0].val]);
                else mdl_err = 1'b1;
                void'(pend_q.pop_front());
            end
            if (acc) begin
                e.val = in_data;
                e.due = edge_n + SBOX_LAT + 1;
                pend_q.push_back(e);
            end
            exp_m1  = rnd[3:0];
            exp_m2  = rnd[7:4];
            exp_xor = acc ? in_data : 4'h0;
        end
        edge_n++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, shortly after each edge.
    always @(posedge clk) begin
        #2;
        if (mdl_live) begin
            checkOutput("in_ready", 32'(in_ready), 32'(mdl_ready()));
            checkOutput("out_valid", 32'(out_valid), 32'(fifo_m.size() > 0));
            if (fifo_m.size() > 0) checkOutput("out_data", 32'(out_data), 32'(fifo_m[0]));
            checkOutput("err_ovf", 32'(err_ovf), 32'(mdl_err));
            checkOutput("sh_in1_mask", 32'(sh_in1), 32'(exp_m1));
            checkOutput("sh_in2_mask", 32'(sh_in2), 32'(exp_m2));
            checkOutput("share_xor", 32'(sh_in1 ^ sh_in2 ^ sh_in3), 32'(exp_xor));
        end
    end

    // Record each result the moment before it is popped.
    always @(negedge clk) begin
        #1;
        if (!rst && out_valid && out_ready) got_q.push_back(out_data);
    end

    task automatic applyStimulus(input logic r_rst, input logic v, input logic [3:0] d,
                                 input logic ordy, input logic [7:0] rn);
        @(negedge clk);
        rst       = r_rst;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        rnd       = rn;
    endtask

    task automatic resetDut();
        repeat (3) applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 8'($urandom));
        @(posedge clk);
        #3;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_err_ovf", 32'(err_ovf), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_sh_in3", 32'(sh_in3), 32'd0);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] single_in  [2];
        logic [3:0] single_exp [2];
        logic [3:0] sent[$];
        logic [3:0] d;
        int         nxt;
        int         guard;
        int         acc;

        single_in  = '{4'h0, 4'h1};
        single_exp = '{4'hC, 4'hA};
        rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0; rnd = 8'h00;

        // Single nibbles: result appears exactly SBOX_LAT+1 edges after accept.
        resetDut();
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b0, 1'b1, single_in[c], 1'b1, 8'($urandom));
            for (int k = 1; k <= SBOX_LAT + 1; k++) begin
                applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 8'($urandom));
                @(posedge clk);
                #3;
                if (k == SBOX_LAT) checkOutput("single_early_valid", 32'(out_valid), 32'd0);
                if (k == SBOX_LAT + 1) begin
                    checkOutput("single_valid", 32'(out_valid), 32'd1);
                    checkOutput("single_data", 32'(out_data), 32'(single_exp[c]));
                end
            end
            repeat (2) applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 8'($urandom));
        end

        // Masking sweep: every rnd value with a fixed plaintext.
        for (int i = 0; i < 256; i++) applyStimulus(1'b0, 1'b1, 4'h5, 1'b1, 8'(i));
        repeat (10) applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 8'($urandom));

        // Stream 0..F with the consumer always ready.
        resetDut();
        got_q.delete();
        nxt = 0;
        guard = 0;
        while (nxt < 16 && guard < 200) begin
            applyStimulus(1'b0, 1'b1, 4'(nxt), 1'b1, 8'($urandom));
            if (mdl_ready()) nxt++;
            guard++;
        end
        checkOutput("stream_sent", 32'(nxt), 32'd16);
        repeat (12) applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 8'($urandom));
        checkOutput("stream_count", 32'(got_q.size()), 32'd16);
        for (int j = 0; j < got_q.size() && j < 16; j++)
            checkOutput("stream_data", 32'(got_q[j]), 32'(SB0[j]));

        // Backpressure: consumer stalled, offers continue.
        resetDut();
        got_q.delete();
        sent.delete();
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            d = 4'($urandom);
            applyStimulus(1'b0, 1'b1, d, 1'b0, 8'($urandom));
            if (mdl_ready()) begin
                acc++;
                sent.push_back(d);
            end
        end
        checkOutput("bp_accepts", 32'(acc), 32'(FIFO_DEPTH));
        @(posedge clk);
        #3;
        checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
        checkOutput("bp_err_ovf", 32'(err_ovf), 32'd0);
        repeat (12) applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 8'($urandom));
        checkOutput("bp_drain_count", 32'(got_q.size()), 32'(sent.size()));
        for (int j = 0; j < got_q.size() && j < sent.size(); j++)
            checkOutput("bp_drain_data", 32'(got_q[j]), 32'(SB0[sent[j]]));

        // Continuous push/pop with a shallow FIFO, many pointer laps.
        resetDut();
        got_q.delete();
        sent.delete();
        for (int i = 0; i < 40; i++) begin
            d = 4'($urandom);
            applyStimulus(1'b0, 1'b1, d, 1'b1, 8'($urandom));
            if (mdl_ready()) sent.push_back(d);
        end
        repeat (12) applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 8'($urandom));
        checkOutput("wrap_count", 32'(got_q.size()), 32'(sent.size()));
        for (int j = 0; j < got_q.size() && j < sent.size(); j++)
            checkOutput("wrap_data", 32'(got_q[j]), 32'(SB0[sent[j]]));

        // Reset with 3 nibbles in flight and 2 results buffered.
        resetDut();
        repeat (2) applyStimulus(1'b0, 1'b1, 4'($urandom), 1'b0, 8'($urandom));
        repeat (7) applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 8'($urandom));
        repeat (3) applyStimulus(1'b0, 1'b1, 4'($urandom), 1'b0, 8'($urandom));
        @(posedge clk);
        #3;
        checkOutput("rmf_buffered", 32'(out_valid), 32'd1);
        got_q.delete();
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 8'($urandom));
        @(posedge clk);
        #3;
        checkOutput("rmf_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rmf_out_data", 32'(out_data), 32'd0);
        checkOutput("rmf_in_ready", 32'(in_ready), 32'd0);
        repeat (15) applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 8'($urandom));
        checkOutput("rmf_stale", 32'(got_q.size()), 32'd0);

        // Random traffic with occasional resets.
        resetDut();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) < 7),
                          4'($urandom), 1'($urandom_range(0, 3) != 0), 8'($urandom));
        end
        repeat (12) applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 8'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
